// File: rtl/reduce_pkg.sv
// Shared types and reduction helper for the reduce/select pipeline.
//   red_op_t : 2-bit reduction opcode (AND, OR, XOR, XNOR)
//   reduce_f : reduces the low 'width' bits of a vector with the given op
package reduce_pkg;

  localparam int unsigned RED_MAX_W = 64;

  typedef enum logic [1:0] {
    RED_AND  = 2'b00,
    RED_OR   = 2'b01,
    RED_XOR  = 2'b10,
    RED_XNOR = 2'b11
  } red_op_t;

  // Bits at or above 'width' are ignored so one function serves every WIDTH.
  function automatic logic reduce_f(input red_op_t                op,
                                    input logic [RED_MAX_W-1:0]   vec,
                                    input int unsigned            width);
    logic v_and;
    logic v_or;
    logic v_xor;
    logic v_res;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int unsigned i = 0; i < RED_MAX_W; i++) begin
      if (i < width) begin
        v_and = v_and & vec[i];
        v_or  = v_or  | vec[i];
        v_xor = v_xor ^ vec[i];
      end
    end
    case (op)
      RED_AND:  v_res = v_and;
      RED_OR:   v_res = v_or;
      RED_XOR:  v_res = v_xor;
      RED_XNOR: v_res = ~v_xor;
      default:  v_res = 1'b0;
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/reduce_unit.sv
// Combinational single-operand reduction.
//   op     : reduction opcode
//   vec    : WIDTH-bit operand
//   result : reduced bit
module reduce_unit
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  red_op_t          op,
  input  logic [WIDTH-1:0] vec,
  output logic             result
);

  assign result = reduce_f(op, RED_MAX_W'(vec), WIDTH);

endmodule

// File: rtl/reduce_select_pipe.sv
// Two-stage valid/ready pipeline: reduce two operands, select one, register
// the result and its complement.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake (in_ready is combinational from out_ready)
//   a_vec, b_vec         : WIDTH-bit operands
//   op_a, op_b           : per-operand reduction opcode
//   sel                  : 0 -> reduced A, 1 -> reduced B
//   out_valid/out_ready  : output handshake
//   out, out_bar         : registered result and its complement
//   stat_clr, ones_count : result-one counter, only with REDUCE_SELECT_STATS_EN
module reduce_select_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_vec,
  input  logic [WIDTH-1:0] b_vec,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef REDUCE_SELECT_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] ones_count,
`endif
  output logic             out,
  output logic             out_bar
);

  // Elaboration-time guard on parameter ranges.
  if (WIDTH < 1 || WIDTH > RED_MAX_W || CNT_W < 1) begin : g_param_check
    $error("reduce_select_pipe: WIDTH must be 1..64 and CNT_W >= 1");
  end

  logic w_red_a;
  logic w_red_b;
  logic w_s1_load;
  logic w_s2_load;
  logic w_out_fire;
  logic w_sel_res;

  logic r_s1_valid;
  logic r_red_a;
  logic r_red_b;
  logic r_sel;
  logic r_out_valid;
  logic r_out;
  logic r_out_bar;

  reduce_unit #(.WIDTH(WIDTH)) u_red_a (
    .op     (red_op_t'(op_a)),
    .vec    (a_vec),
    .result (w_red_a)
  );

  reduce_unit #(.WIDTH(WIDTH)) u_red_b (
    .op     (red_op_t'(op_b)),
    .vec    (b_vec),
    .result (w_red_b)
  );

  // Handshake: stage 2 drains or is empty, stage 1 may refill in the same cycle.
  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_s1_load  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_sel_res  = r_sel ? r_red_b : r_red_a;

  // Stage 1: reduction results and select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_red_a    <= 1'b0;
      r_red_b    <= 1'b0;
      r_sel      <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_red_a    <= w_red_a;
      r_red_b    <= w_red_b;
      r_sel      <= sel;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: selected result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= 1'b0;
      r_out_bar   <= 1'b1;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out       <= w_sel_res;
      r_out_bar   <= ~w_sel_res;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_bar   = r_out_bar;

`ifdef REDUCE_SELECT_STATS_EN
  logic [CNT_W-1:0] r_ones_count;

  // Saturating count of delivered ones; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_count <= '0;
    end else if (stat_clr) begin
      r_ones_count <= '0;
    end else if (w_out_fire && r_out && (r_ones_count != {CNT_W{1'b1}})) begin
      r_ones_count <= r_ones_count + CNT_W'(1);
    end
  end

  assign ones_count = r_ones_count;
`endif

endmodule
